// File: rtl/data_sync_pkg.sv
// data_sync_pkg: edge-detect mode constants and channel-index width helper
package data_sync_pkg;
    localparam int DS_LEVEL  = 0;
    localparam int DS_TOGGLE = 1;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/data_sync_ch.sv
// data_sync_ch: one enable synchroniser, edge detector and holding register
module data_sync_ch
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int MODE       = DS_LEVEL
) (
    input  logic                 CLK,
    input  logic                 rst_n,
    input  logic                 bus_enable,
    input  logic [BUS_WIDTH-1:0] unsync_bus,
    input  logic                 grant,
    input  logic                 ovf_clr,
    output logic                 enable_pulse,
    output logic                 hold_valid,
    output logic [BUS_WIDTH-1:0] hold_data,
    output logic                 overflow
);
    logic [NUM_STAGES-1:0] sync_q;
    logic sync, prev, detect;

    assign sync   = sync_q[NUM_STAGES-1];
    assign detect = (MODE == DS_TOGGLE) ? sync ^ prev : sync & ~prev;

    // A grant in the capture cycle frees the slot, so the new word is not an overflow
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev         <= 1'b0;
            enable_pulse <= 1'b0;
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            overflow     <= 1'b0;
        end else begin
            sync_q       <= {sync_q[NUM_STAGES-2:0], bus_enable};
            prev         <= sync;
            enable_pulse <= detect;
            hold_valid   <= detect | (hold_valid & ~grant);
            if (detect) hold_data <= unsync_bus;
            overflow     <= (detect & hold_valid & ~grant) | (overflow & ~ovf_clr);
        end
    end
endmodule

// File: rtl/data_sync_mc.sv
// data_sync_mc: multi-channel enable-qualified synchroniser with
// round-robin drain onto a single tagged valid/ready stream
module data_sync_mc
    import data_sync_pkg::*;
#(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 4,
    parameter int MODE       = DS_LEVEL,
    parameter int CH_W       = ch_width(NUM_CH)
) (
    input  logic                        CLK,
    input  logic                        rst_n,
    input  logic [NUM_CH-1:0]           bus_enable,
    input  logic [NUM_CH*BUS_WIDTH-1:0] unsync_bus,
    output logic [NUM_CH-1:0]           enable_pulse,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BUS_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic [NUM_CH-1:0]           overflow,
    input  logic                        ovf_clr
);
    logic [NUM_CH-1:0]    hv;
    logic [BUS_WIDTH-1:0] hd [NUM_CH];
    logic [CH_W-1:0]      rr_ptr, gnt_idx, cand;
    logic                 found, free, take;

    assign free = ~out_valid | out_ready;
    assign take = free & found;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        data_sync_ch #(
            .BUS_WIDTH (BUS_WIDTH),
            .NUM_STAGES(NUM_STAGES),
            .MODE      (MODE)
        ) u_ch (
            .CLK         (CLK),
            .rst_n       (rst_n),
            .bus_enable  (bus_enable[c]),
            .unsync_bus  (unsync_bus[c*BUS_WIDTH +: BUS_WIDTH]),
            .grant       (take && (gnt_idx == CH_W'(c))),
            .ovf_clr     (ovf_clr),
            .enable_pulse(enable_pulse[c]),
            .hold_valid  (hv[c]),
            .hold_data   (hd[c]),
            .overflow    (overflow[c])
        );
    end

    // Search starts one past the last grant so every pending channel waits at most NUM_CH-1 grants
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((int'(rr_ptr) + i) % NUM_CH);
            if (!found && hv[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            rr_ptr    <= CH_W'(NUM_CH - 1);
        end else if (free) begin
            out_valid <= found;
            if (found) begin
                out_data <= hd[gnt_idx];
                out_ch   <= gnt_idx;
                rr_ptr   <= gnt_idx;
            end
        end
    end
endmodule

// File: tb/tb_data_sync_mc.sv
// tb_data_sync_mc: directed checks on a level-mode and a toggle-mode instance
// sharing one stimulus set
module tb_data_sync_mc;
    import data_sync_pkg::*;

    logic        CLK = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  bus_enable = '0;
    logic [31:0] unsync_bus = '0;
    logic        out_ready = 1'b0;
    logic        ovf_clr = 1'b0;
    logic [3:0]  l_pulse, t_pulse, l_ovf, t_ovf;
    logic        l_valid, t_valid;
    logic [7:0]  l_data, t_data;
    logic [1:0]  l_ch, t_ch;
    int          tests = 0;
    int          fails = 0;

    always #5 CLK = ~CLK;

    data_sync_mc #(.MODE(DS_LEVEL)) u_lvl (
        .CLK(CLK), .rst_n(rst_n), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .enable_pulse(l_pulse), .out_valid(l_valid), .out_ready(out_ready),
        .out_data(l_data), .out_ch(l_ch), .overflow(l_ovf), .ovf_clr(ovf_clr)
    );

    data_sync_mc #(.MODE(DS_TOGGLE)) u_tog (
        .CLK(CLK), .rst_n(rst_n), .bus_enable(bus_enable), .unsync_bus(unsync_bus),
        .enable_pulse(t_pulse), .out_valid(t_valid), .out_ready(out_ready),
        .out_data(t_data), .out_ch(t_ch), .overflow(t_ovf), .ovf_clr(ovf_clr)
    );

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_enable = '0;
        unsync_bus = '0;
        out_ready = 1'b0;
        ovf_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({l_pulse, l_valid, l_data, l_ch, l_ovf} !== 19'd0) begin
            fails++;
            $display("FAIL reset_lvl: got pulse=%b valid=%b data=%h ch=%0d ovf=%b, want all 0",
                     l_pulse, l_valid, l_data, l_ch, l_ovf);
        end
        tests++;
        if ({t_pulse, t_valid, t_data, t_ch, t_ovf} !== 19'd0) begin
            fails++;
            $display("FAIL reset_tog: got pulse=%b valid=%b data=%h ch=%0d ovf=%b, want all 0",
                     t_pulse, t_valid, t_data, t_ch, t_ovf);
        end
    endtask

    task automatic test_level();
        int pulses = 0, pulse_edge = 0, valid_edge = 0;
        do_reset();
        unsync_bus[7:0] = 8'hA5;
        bus_enable[0] = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (l_pulse[0]) begin
                pulses++;
                pulse_edge = e;
            end
            if (l_valid && valid_edge == 0) begin
                valid_edge = e;
                tests++;
                if (l_data !== 8'hA5 || l_ch !== 2'd0) begin
                    fails++;
                    $display("FAIL level_word: got data=%h ch=%0d, want a5 ch 0", l_data, l_ch);
                end
            end
        end
        tests++;
        if (pulses !== 1 || pulse_edge !== 3) begin
            fails++;
            $display("FAIL level_pulse: got %0d pulses last at edge %0d, want 1 at edge 3", pulses, pulse_edge);
        end
        tests++;
        if (valid_edge !== 4) begin
            fails++;
            $display("FAIL level_latency: got out_valid at edge %0d, want 4", valid_edge);
        end
        bus_enable[0] = 1'b0;
    endtask

    task automatic test_toggle();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] words [8];
        logic [1:0] chs [8];
        int n = 0, pulses = 0;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            if (i % 5 == 0 && i <= 10) begin
                unsync_bus[23:16] = vals[i/5];
                bus_enable[2] = ~bus_enable[2];
            end
            tick();
            if (t_pulse[2]) pulses++;
            if (t_valid && n < 8) begin
                words[n] = t_data;
                chs[n] = t_ch;
                n++;
            end
        end
        tests++;
        if (pulses !== 3 || n !== 3) begin
            fails++;
            $display("FAIL toggle_count: got %0d pulses %0d words, want 3 and 3", pulses, n);
        end
        for (int k = 0; k < 3 && k < n; k++) begin
            tests++;
            if (words[k] !== vals[k] || chs[k] !== 2'd2) begin
                fails++;
                $display("FAIL toggle_word%0d: got %h ch %0d, want %h ch 2", k, words[k], chs[k], vals[k]);
            end
        end
        tests++;
        if (t_ovf !== 4'b0) begin
            fails++;
            $display("FAIL toggle_ovf: got %b, want 0000", t_ovf);
        end
        bus_enable = '0;
    endtask

    task automatic test_round_robin();
        logic [1:0] exp1 [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
        logic [1:0] exp2 [4] = '{2'd2, 2'd3, 2'd0, 2'd1};
        logic [1:0] chs [8];
        logic [7:0] dat [8];
        int n;
        do_reset();
        out_ready = 1'b1;
        unsync_bus = 32'h13121110;
        for (int b = 0; b < 2; b++) begin
            n = 0;
            bus_enable = 4'hF;
            for (int i = 0; i < 10; i++) begin
                tick();
                if (l_valid && n < 8) begin
                    chs[n] = l_ch;
                    dat[n] = l_data;
                    n++;
                end
            end
            tests++;
            if (n !== 4) begin
                fails++;
                $display("FAIL rr%0d_count: got %0d words, want 4", b, n);
            end
            for (int k = 0; k < 4 && k < n; k++) begin
                tests++;
                if (chs[k] !== (b == 0 ? exp1[k] : exp2[k]) || dat[k] !== 8'h10 + 8'(chs[k])) begin
                    fails++;
                    $display("FAIL rr%0d_grant%0d: got ch %0d data %h, want ch %0d", b, k, chs[k], dat[k],
                             b == 0 ? exp1[k] : exp2[k]);
                end
            end
            bus_enable = '0;
            tick(4);
            if (b == 0) begin
                bus_enable = 4'b0010;
                tick(6);
                bus_enable = '0;
                tick(4);
            end
        end
    endtask

    task automatic test_overflow();
        logic [7:0] words [4];
        logic [1:0] chs [4];
        int n = 0;
        do_reset();
        unsync_bus[7:0] = 8'h0F;
        bus_enable[0] = 1'b1;
        tick(5);
        unsync_bus[15:8] = 8'h41;
        bus_enable[1] = 1'b1;
        tick(4);
        bus_enable[1] = 1'b0;
        tick(3);
        unsync_bus[15:8] = 8'h42;
        bus_enable[1] = 1'b1;
        tick(4);
        tests++;
        if (l_ovf !== 4'b0010) begin
            fails++;
            $display("FAIL ovf_set: got %b, want 0010", l_ovf);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (l_valid && n < 4) begin
                words[n] = l_data;
                chs[n] = l_ch;
                n++;
            end
            tick();
        end
        out_ready = 1'b0;
        tests++;
        if (n !== 2 || words[0] !== 8'h0F || chs[0] !== 2'd0 || words[1] !== 8'h42 || chs[1] !== 2'd1) begin
            fails++;
            $display("FAIL ovf_drain: got %0d words (%h ch%0d, %h ch%0d), want 0f ch0 then 42 ch1",
                     n, words[0], chs[0], words[1], chs[1]);
        end
        tests++;
        if (l_ovf !== 4'b0010) begin
            fails++;
            $display("FAIL ovf_sticky: got %b, want 0010", l_ovf);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests++;
        if (l_ovf !== 4'b0000) begin
            fails++;
            $display("FAIL ovf_clear: got %b, want 0000", l_ovf);
        end
        bus_enable[1] = 1'b0;
        tick(3);
        unsync_bus[15:8] = 8'h51;
        bus_enable[1] = 1'b1;
        tick(4);
        bus_enable[1] = 1'b0;
        tick(3);
        unsync_bus[15:8] = 8'h52;
        bus_enable[1] = 1'b1;
        tick(4);
        tests++;
        if (l_ovf !== 4'b0000) begin
            fails++;
            $display("FAIL ovf_none_single: got %b, want 0000", l_ovf);
        end
        bus_enable[1] = 1'b0;
        tick(3);
        unsync_bus[15:8] = 8'h53;
        bus_enable[1] = 1'b1;
        tick(2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        tests++;
        if (l_ovf !== 4'b0010 || l_pulse !== 4'b0010) begin
            fails++;
            $display("FAIL ovf_set_wins: got ovf=%b pulse=%b, want 0010 0010", l_ovf, l_pulse);
        end
    endtask

    task automatic test_backpressure();
        int xfers = 0;
        do_reset();
        unsync_bus[31:24] = 8'h3C;
        bus_enable[3] = 1'b1;
        tick(4);
        for (int i = 0; i < 6; i++) begin
            tick();
            tests++;
            if (l_valid !== 1'b1 || l_data !== 8'h3C || l_ch !== 2'd3) begin
                fails++;
                $display("FAIL bp_hold%0d: got valid=%b data=%h ch=%0d, want 1 3c 3", i, l_valid, l_data, l_ch);
            end
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (l_valid) xfers++;
            tick();
        end
        tests++;
        if (xfers !== 1) begin
            fails++;
            $display("FAIL bp_release: got %0d transfers, want 1", xfers);
        end
    endtask

    task automatic test_async_reset();
        int p0 = 0, pother = 0, n = 0;
        logic [7:0] word = '0;
        logic [1:0] ch = '1;
        do_reset();
        unsync_bus = 32'h44332211;
        bus_enable = 4'hF;
        tick(6);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({l_pulse, l_valid, l_data, l_ch, l_ovf} !== 19'd0) begin
            fails++;
            $display("FAIL async_reset: got pulse=%b valid=%b data=%h ch=%0d ovf=%b, want all 0",
                     l_pulse, l_valid, l_data, l_ch, l_ovf);
        end
        bus_enable = 4'b0001;
        unsync_bus[7:0] = 8'h77;
        tick(2);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (l_pulse[0]) p0++;
            if (|l_pulse[3:1]) pother++;
            if (l_valid) begin
                n++;
                word = l_data;
                ch = l_ch;
            end
        end
        tests++;
        if (p0 !== 1 || pother !== 0) begin
            fails++;
            $display("FAIL reset_release_pulse: got ch0=%0d other=%0d pulses, want 1 and 0", p0, pother);
        end
        tests++;
        if (n !== 1 || word !== 8'h77 || ch !== 2'd0) begin
            fails++;
            $display("FAIL reset_release_word: got %0d words last %h ch %0d, want 1 word 77 ch 0", n, word, ch);
        end
    endtask

    initial begin
        test_reset();
        test_level();
        test_toggle();
        test_round_robin();
        test_overflow();
        test_backpressure();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
